// File: rtl/spi_board_arb_if.sv
// spi_board_arb_if: request side and shared SPI bus of the four-board SPI arbiter.
// master = board/test side, slave = arbiter side.
interface spi_board_arb_if #(
  parameter int WORD_BITS = 24
);
  logic [3:0]             req;
  logic [7:0]             dev;
  logic [4*WORD_BITS-1:0] tx_data;
  logic [3:0]             live;
  logic [3:0]             miso;
  logic [3:0]             ack;
  logic [3:0]             err;
  logic [WORD_BITS-1:0]   rx_data;
  logic                   busy;
  logic [3:0]             oe;
  logic [11:0]            csn;
  logic                   sclk;
  logic                   mosi;

  modport master (
    output req, dev, tx_data, live, miso,
    input  ack, err, rx_data, busy, oe, csn, sclk, mosi
  );

  modport slave (
    input  req, dev, tx_data, live, miso,
    output ack, err, rx_data, busy, oe, csn, sclk, mosi
  );
endinterface

// File: rtl/spi_board_arb.sv
// spi_board_arb: round-robin arbiter granting one of four boards a mode-0 SPI
// transaction to one of three ADCs on that board over a shared SCLK/MOSI.
// Optional macro SPI_BOARD_ARB_LIVE_MASK_EN: synchronizes the live inputs and
// rejects grants to absent boards with an err pulse.
module spi_board_arb #(
  parameter int CLK_DIV   = 25,
  parameter int WORD_BITS = 24,
  parameter int CS_GAP    = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_board_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP, DONE} state_t;

  state_t               state, nxt;
  logic [1:0]           last_grant, grant, pick, pick_dev, dev_q;
  logic                 found, grant_bad;
  logic [7:0]           cnt;
  logic [5:0]           bit_cnt;
  logic [WORD_BITS-1:0] tx_sh, rx_sh, rx_q;
  logic [3:0]           err_q, board_ok;
  logic [3:0]           csn_idx;
  logic [11:0]          csn_c;
  logic [3:0]           oe_c, ack_c;
  logic                 sclk_c, div_end, gap_end, last_bit;

`ifdef SPI_BOARD_ARB_LIVE_MASK_EN
  logic [1:0][3:0] live_pipe;

  // two-flop synchronizer for the asynchronous board-present inputs
  always_ff @(posedge clk) begin
    if (rst) live_pipe <= '0;
    else     live_pipe <= {live_pipe[0], bus.live};
  end
  assign board_ok = live_pipe[1];
`else
  logic unused_live;
  assign unused_live = ^bus.live;
  assign board_ok    = 4'hF;
`endif

  // round-robin search starting one past the last served board
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && bus.req[2'(last_grant + 2'(i))]) begin
        pick  = 2'(last_grant + 2'(i));
        found = 1'b1;
      end
    end
  end

  assign pick_dev  = bus.dev[{pick, 1'b0} +: 2];
  assign grant_bad = (pick_dev == 2'd3) || !board_ok[pick];
  assign div_end   = (cnt == 8'(CLK_DIV - 1));
  assign gap_end   = (cnt == 8'(CS_GAP - 1));
  assign last_bit  = (bit_cnt == 6'(WORD_BITS - 1));

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (found && !grant_bad) nxt = SETUP;
      SETUP:   if (div_end) nxt = LOW;
      LOW:     if (div_end) nxt = HIGH;
      HIGH:    if (div_end) nxt = last_bit ? HOLD : LOW;
      HOLD:    if (div_end) nxt = GAP;
      GAP:     if (gap_end) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state register, phase counter, shift registers and grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      grant      <= 2'd0;
      dev_q      <= 2'd0;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_q       <= '0;
      err_q      <= '0;
    end else begin
      state <= nxt;
      err_q <= '0;
      cnt   <= (nxt != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
      unique case (state)
        IDLE: if (found) begin
          if (grant_bad) begin
            // rejected grant still advances the round-robin pointer
            err_q      <= 4'b0001 << pick;
            last_grant <= pick;
          end else begin
            grant   <= pick;
            dev_q   <= pick_dev;
            tx_sh   <= bus.tx_data[pick*WORD_BITS +: WORD_BITS];
            bit_cnt <= '0;
          end
        end
        LOW:  if (nxt == HIGH) rx_sh <= {rx_sh[WORD_BITS-2:0], bus.miso[grant]};
        HIGH: if (nxt == LOW) begin
          tx_sh   <= tx_sh << 1;
          bit_cnt <= bit_cnt + 6'd1;
        end
        GAP:  if (nxt == DONE) rx_q <= rx_sh;
        DONE: last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign csn_idx = {1'b0, grant, 1'b0} + {2'b00, grant} + {2'b00, dev_q};

  // bus outputs decoded from state: chip select, driver enable, clock, ack
  always_comb begin
    csn_c  = 12'hFFF;
    oe_c   = '0;
    sclk_c = 1'b0;
    ack_c  = '0;
    unique case (state)
      SETUP, LOW, HOLD: begin
        csn_c[csn_idx] = 1'b0;
        oe_c[grant]    = 1'b1;
      end
      HIGH: begin
        csn_c[csn_idx] = 1'b0;
        oe_c[grant]    = 1'b1;
        sclk_c         = 1'b1;
      end
      GAP:     oe_c[grant]  = 1'b1;
      DONE:    ack_c[grant] = 1'b1;
      default: ;
    endcase
  end

  assign bus.csn     = csn_c;
  assign bus.oe      = oe_c;
  assign bus.sclk    = sclk_c;
  assign bus.ack     = ack_c;
  assign bus.mosi    = tx_sh[WORD_BITS-1];
  assign bus.err     = err_q;
  assign bus.rx_data = rx_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: doc/spi_board_arb.md
SPI_BOARD_ARB -- requirements
Module: spi_board_arb

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, meaning the SCLK half-period in clk cycles (1 MHz at 50 MHz); legal range 2..255.
REQ-002 SHALL have parameter WORD_BITS, default 24, meaning the bits per transaction; legal range 8..32.
REQ-003 SHALL have parameter CS_GAP, default 4, meaning the clk cycles with csn deasserted between transactions; legal range 1..255.
REQ-004 clk  in  1  single clock; one clock, reset synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  4  level request per board A..D, held until ack.
REQ-007 dev  in  8  2-bit device select per board (bits 2b+1:2b); 0/1/2 = ADC a/b/c, 3 = invalid.
REQ-008 tx_data  in  4*WORD_BITS  per-board transmit word, board b at bits [b*WORD_BITS +: WORD_BITS].
REQ-009 live  in  4  board-present inputs, asynchronous.
REQ-010 miso  in  4  per-board MISO.
REQ-011 ack  out  4  one-cycle completion pulse per board.
REQ-012 err  out  4  one-cycle rejection pulse per board.
REQ-013 rx_data  out  WORD_BITS  received word, valid in the ack cycle and held until the next ack.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 oe  out  4  one-hot driver enable for the granted board.
REQ-016 csn  out  12  active-low chip selects; index 3*board+dev.
REQ-017 sclk, mosi  out  1 each  shared SPI, mode 0.

Function
REQ-018 States SHALL be IDLE, SETUP, LOW, HIGH, HOLD, GAP, DONE.
REQ-019 IDLE: on any req, SHALL grant round-robin starting at last_grant+1 mod 4; the granted board's dev and tx_data SHALL be latched; next state is SETUP.
REQ-020 If the latched dev==3, SHALL pulse err[grant] for 1 cycle in the cycle after the grant, update last_grant, and return to IDLE with no csn/oe activity.
REQ-021 SETUP: oe[grant] and csn[3*grant+dev] low for CLK_DIV cycles with sclk=0; mosi=MSB.
REQ-022 LOW/HIGH: each bit SHALL be sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles, MSB first; mosi changes only on entry to LOW.
REQ-023 miso[grant] SHALL be registered on entry to HIGH (the sclk rising edge); the MISO inputs of non-granted boards SHALL be ignored.
REQ-024 After WORD_BITS bits: HOLD (sclk=0, csn low) for CLK_DIV cycles, then GAP (all csn high, oe held) for CS_GAP cycles.
REQ-025 DONE: oe=0, ack[grant]=1 and rx_data updated in the same cycle, last_grant=grant; next state is IDLE.
REQ-026 req still high in the cycle after ack SHALL count as a new request; dropping req mid-transaction SHALL NOT abort it, and ack still pulses.
REQ-027 csn SHALL be one-hot-low or all-high at all times; oe SHALL be one-hot or zero; oe SHALL be high in every cycle in which csn is low.
REQ-028 Transaction length SHALL be exactly 1 + CLK_DIV*(2*WORD_BITS+2) + CS_GAP + 1 cycles from grant to ack.

Reset
REQ-029 With rst high at a clk edge: state=IDLE, csn=12'hFFF, oe=0, sclk=0, mosi=0, ack=0, err=0, busy=0, rx_data=0, last_grant=3 (so board A is served first).
REQ-030 Reset mid-transaction SHALL take effect at the next edge with no ack or err issued.

Configuration
REQ-031 Macro SPI_BOARD_ARB_LIVE_MASK_EN: when defined, live SHALL pass through a 2-flop synchronizer, and a grant to a board whose synchronized live is 0 SHALL behave as in REQ-020 (err pulse, no bus activity); live is checked only at grant time.
REQ-032 Without SPI_BOARD_ARB_LIVE_MASK_EN, live SHALL be ignored and no synchronizer flops are built.

Verification
REQ-033 CLK_DIV=2, WORD_BITS=8: req[0], dev=1, tx=8'hA5, miso[0] fed 8'h3C -> csn[1] low, mosi bits 1,0,1,0,0,1,0,1, ack[0] pulses at cycle 1+2*18+4+1=42, rx_data=8'h3C.
REQ-034 req=4'b1111 held continuously -> grants in order A,B,C,D,A; exactly one ack per transaction; never two csn low at once.
REQ-035 req[2] with dev=3 -> err[2] pulse 1 cycle after grant, csn=12'hFFF and oe=0 throughout, next grant goes to board D.
REQ-036 LIVE_MASK_EN defined, live=4'b1101, req[1] -> err[1], no SPI activity; macro undefined -> normal transaction and ack[1].
REQ-037 rst asserted during the 3rd bit -> next cycle csn=12'hFFF, oe=0, sclk=0, busy=0; no ack follows.
REQ-038 req[3] dropped during SHIFT -> transaction completes and ack[3] still pulses.
